// File: rtl/apb_master_pkg.sv
// ============================================================================
//  Module   : apb_master_pkg
//  Purpose  : Shared FSM state encoding and defaults for the APB command master.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    // Wide enough for the largest supported wait-state limit (255).
    typedef logic [7:0] wait_cnt_t;

endpackage

`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
// ============================================================================
//  Module   : apb_timeout_cnt
//  Purpose  : ACCESS-phase wait-state counter with a single-cycle expiry flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module apb_timeout_cnt
    import apb_master_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam wait_cnt_t LAST = wait_cnt_t'(LIMIT - 1);

    wait_cnt_t count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Flags the edge on which the count would reach LIMIT.
    assign expired = enable && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/apb_cmd_master.sv
// ============================================================================
//  Module   : apb_cmd_master
//  Purpose  : Converts single valid/ready commands into APB transfers with timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int unsigned AWIDTH  = 8,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [AWIDTH-1:0] CMD_ADDR,
    input  logic [DWIDTH-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DWIDTH-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_t state;
    apb_state_t state_next;
    logic       ready_en;
    logic       cmd_accept;
    logic       cnt_clear;
    logic       cnt_enable;
    logic       timeout_hit;

    assign cmd_accept = CMD_VALID && CMD_READY;
    assign cnt_clear  = (state == ST_SETUP);
    assign cnt_enable = (state == ST_ACCESS) && !PREADY;

    apb_timeout_cnt #(
        .LIMIT   (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (PCLK),
        .rst_n   (PRESETN),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (timeout_hit)
    );

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (cmd_accept)                state_next = ST_SETUP;
            ST_SETUP:                                 state_next = ST_ACCESS;
            ST_ACCESS: if (PREADY || timeout_hit)     state_next = ST_RESP;
            ST_RESP:   if (RSP_READY)                 state_next = ST_IDLE;
            default:                                  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        CMD_READY = (state == ST_IDLE) && ready_en;
        PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
        PENABLE   = (state == ST_ACCESS);
        RSP_VALID = (state == ST_RESP);
    end

    // Holds CMD_READY low until the first edge after reset release.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (cmd_accept) begin
            PWRITE <= CMD_WRITE;
            PADDR  <= CMD_ADDR;
            PWDATA <= CMD_WDATA;
        end
    end

    // Completion takes priority over a coincident timeout.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (PREADY) begin
                RSP_RDATA <= PWRITE ? '0 : PRDATA;
                RSP_ERR   <= PSLVERR;
            end else if (timeout_hit) begin
                RSP_RDATA <= '0;
                RSP_ERR   <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
